// File: rtl/adc_conv_scheduler.sv
// Burst scheduler for a SAR ADC: paces start pulses, captures results and signals burst end.
// Optional WAIT-state watchdog enabled by defining ADC_SCHED_TIMEOUT_EN.
module adc_conv_scheduler #(
    parameter int RESULT_W       = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_conversion_in,
    input  logic                abort_in,
    input  logic                continuous_in,
    input  logic [7:0]          burst_len_in,
    input  logic [5:0]          holdoff_in,
    input  logic                sar_valid_in,
    input  logic [RESULT_W-1:0] sar_result_in,
    output logic                sar_start_out,
    output logic                sar_ena_out,
    output logic [RESULT_W-1:0] result_out,
    output logic                result_valid_out,
    output logic                conversion_finished_out,
    output logic                busy_out,
    output logic                timeout_err_out
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]          state;
    logic                start_q;
    logic                edge_en;
    logic [7:0]          burst_len_q;
    logic [7:0]          remaining;
    logic [5:0]          holdoff_q;
    logic [5:0]          hold_cnt;
    logic [TO_W-1:0]     wait_cnt;
    logic                result_valid_q;
    logic                finished_q;
    logic                timeout_err_q;
    logic [RESULT_W-1:0] result_q;

    logic       start_edge;
    logic       timeout_hit;
    logic [7:0] remaining_dec;
    logic [7:0] burst_len_eff;

    // edge_en masks the first cycle after reset so a level held through release is not an edge
    assign start_edge    = start_conversion_in & ~start_q & edge_en;
    assign timeout_hit   = TIMEOUT_EN && (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign remaining_dec = remaining - 8'd1;
    assign burst_len_eff = (burst_len_in == 8'd0) ? 8'd1 : burst_len_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            start_q        <= 1'b0;
            edge_en        <= 1'b0;
            burst_len_q    <= 8'd0;
            remaining      <= 8'd0;
            holdoff_q      <= 6'd0;
            hold_cnt       <= 6'd0;
            wait_cnt       <= '0;
            result_valid_q <= 1'b0;
            finished_q     <= 1'b0;
            timeout_err_q  <= 1'b0;
            result_q       <= '0;
        end else begin
            start_q        <= start_conversion_in;
            edge_en        <= 1'b1;
            result_valid_q <= 1'b0;
            finished_q     <= 1'b0;
            if (abort_in) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_edge) begin
                            state         <= ST_ARM;
                            burst_len_q   <= burst_len_eff;
                            remaining     <= burst_len_eff;
                            holdoff_q     <= holdoff_in;
                            timeout_err_q <= 1'b0;
                        end
                    end
                    ST_ARM: begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                    ST_WAIT: begin
                        if (sar_valid_in) begin
                            result_q       <= sar_result_in;
                            result_valid_q <= 1'b1;
                            finished_q     <= (remaining_dec == 8'd0);
                            if (remaining_dec != 8'd0 || continuous_in) begin
                                remaining <= (remaining_dec != 8'd0) ? remaining_dec : burst_len_q;
                                if (holdoff_q != 6'd0) begin
                                    state    <= ST_HOLD;
                                    hold_cnt <= holdoff_q;
                                end else begin
                                    state <= ST_ARM;
                                end
                            end else begin
                                remaining <= 8'd0;
                                state     <= ST_IDLE;
                            end
                        end else if (timeout_hit) begin
                            timeout_err_q <= 1'b1;
                            state         <= ST_IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        hold_cnt <= hold_cnt - 6'd1;
                        if (hold_cnt == 6'd1) begin
                            state <= ST_ARM;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign sar_start_out           = (state == ST_ARM);
    assign sar_ena_out             = (state != ST_IDLE);
    assign busy_out                = (state != ST_IDLE);
    assign result_out              = result_q;
    assign result_valid_out        = result_valid_q;
    assign conversion_finished_out = finished_q;
    assign timeout_err_out         = timeout_err_q;
endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Directed bench for adc_conv_scheduler: burst vector table plus hand-written corner sequences.
module tb_adc_conv_scheduler;
    localparam int RW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_conversion_in;
    logic          abort_in;
    logic          continuous_in;
    logic [7:0]    burst_len_in;
    logic [5:0]    holdoff_in;
    logic          sar_valid_in;
    logic [RW-1:0] sar_result_in;
    logic          sar_start_out;
    logic          sar_ena_out;
    logic [RW-1:0] result_out;
    logic          result_valid_out;
    logic          conversion_finished_out;
    logic          busy_out;
    logic          timeout_err_out;

    adc_conv_scheduler #(.RESULT_W(RW), .TIMEOUT_CYCLES(255)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .start_conversion_in     (start_conversion_in),
        .abort_in                (abort_in),
        .continuous_in           (continuous_in),
        .burst_len_in            (burst_len_in),
        .holdoff_in              (holdoff_in),
        .sar_valid_in            (sar_valid_in),
        .sar_result_in           (sar_result_in),
        .sar_start_out           (sar_start_out),
        .sar_ena_out             (sar_ena_out),
        .result_out              (result_out),
        .result_valid_out        (result_valid_out),
        .conversion_finished_out (conversion_finished_out),
        .busy_out                (busy_out),
        .timeout_err_out         (timeout_err_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [RW-1:0] exp_q[$];

    typedef struct {
        logic [7:0]    burst_len;
        logic [5:0]    holdoff;
        logic [RW-1:0] base;
        int            delay;
        int            drop_at;
        int            exp_starts;
        int            exp_results;
        int            exp_fin;
        logic [RW-1:0] exp_last;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " result_out"}, 32'(result_out), 32'h0);
        check({tag, " sar_start"}, 32'(sar_start_out), 32'h0);
        check({tag, " sar_ena"}, 32'(sar_ena_out), 32'h0);
        check({tag, " result_valid"}, 32'(result_valid_out), 32'h0);
        check({tag, " finished"}, 32'(conversion_finished_out), 32'h0);
        check({tag, " busy"}, 32'(busy_out), 32'h0);
        check({tag, " timeout_err"}, 32'(timeout_err_out), 32'h0);
    endtask

    // SAR model answers v.delay cycles after each observed start pulse with base + index
    task automatic run_vec(input vec_t v, input string tag);
        int cyc = 0, since = 0, n_starts = 0, n_res = 0, n_fin = 0, n_conv = 0;
        int last_cap = 0, gap_bad = 0, fin_alone = 0, dup = 0;
        bit pending = 0, have_cap = 0, done = 0;
        logic prev_start = 0, prev_valid = 0, prev_fin = 0;
        burst_len_in  = v.burst_len;
        holdoff_in    = v.holdoff;
        continuous_in = (v.drop_at > 0);
        exp_q.delete();
        while (!done && cyc < 2000) begin
            @(negedge clk);
            if ((sar_start_out && prev_start) || (result_valid_out && prev_valid) ||
                (conversion_finished_out && prev_fin)) dup++;
            prev_start = sar_start_out;
            prev_valid = result_valid_out;
            prev_fin   = conversion_finished_out;
            if (sar_start_out) begin
                n_starts++;
                if (have_cap && (cyc - last_cap != int'(v.holdoff) + 1)) gap_bad++;
                pending = 1;
                since   = 0;
                if (n_starts == v.drop_at) continuous_in = 1'b0;
            end
            if (result_valid_out) begin
                n_res++;
                if (exp_q.size() > 0) check({tag, " result"}, 32'(result_out), 32'(exp_q.pop_front()));
            end
            if (conversion_finished_out) begin
                n_fin++;
                if (!result_valid_out) fin_alone++;
            end
            sar_valid_in = 1'b0;
            if (pending) begin
                if (since == v.delay) begin
                    sar_valid_in  = 1'b1;
                    sar_result_in = v.base + RW'(n_conv);
                    exp_q.push_back(sar_result_in);
                    n_conv++;
                    pending  = 0;
                    last_cap = cyc;
                    have_cap = 1;
                end
                since++;
            end
            start_conversion_in = (cyc < 2);
            if (cyc > 3 && !busy_out && !pending) done = 1;
            cyc++;
        end
        check({tag, " completed"}, 32'(done), 32'h1);
        check({tag, " starts"}, 32'(n_starts), 32'(v.exp_starts));
        check({tag, " results"}, 32'(n_res), 32'(v.exp_results));
        check({tag, " finished"}, 32'(n_fin), 32'(v.exp_fin));
        check({tag, " fin_coincident"}, 32'(fin_alone), 32'h0);
        check({tag, " holdoff_gap"}, 32'(gap_bad), 32'h0);
        check({tag, " no_double_pulse"}, 32'(dup), 32'h0);
        check({tag, " last_result"}, 32'(result_out), 32'(v.exp_last));
        check({tag, " pending_results"}, 32'(exp_q.size()), 32'h0);
        check({tag, " idle_at_end"}, 32'(busy_out), 32'h0);
        continuous_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_wait;
        int n_fin_to;
        vecs[0] = '{8'd3, 6'd2,  16'h0100, 5, 0, 3, 3, 1, 16'h0102};
        vecs[1] = '{8'd0, 6'd0,  16'h0ABC, 5, 0, 1, 1, 1, 16'h0ABC};
        vecs[2] = '{8'd1, 6'd5,  16'h1234, 1, 0, 1, 1, 1, 16'h1234};
        vecs[3] = '{8'd4, 6'd0,  16'hFFF0, 2, 0, 4, 4, 1, 16'hFFF3};
        vecs[4] = '{8'd2, 6'd63, 16'h0042, 3, 0, 2, 2, 1, 16'h0043};
        vecs[5] = '{8'd2, 6'd0,  16'h2000, 2, 3, 4, 4, 2, 16'h2003};

        // reset with start held high through release
        rst = 1'b1;
        start_conversion_in = 1'b1;
        abort_in = 1'b0;
        continuous_in = 1'b0;
        burst_len_in = 8'd1;
        holdoff_in = 6'd0;
        sar_valid_in = 1'b0;
        sar_result_in = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("held_start_no_edge busy", 32'(busy_out), 32'h0);
        check("held_start_no_edge sar_start", 32'(sar_start_out), 32'h0);
        start_conversion_in = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // sar_valid while idle must be ignored
        sar_valid_in = 1'b1;
        sar_result_in = 16'h7777;
        @(negedge clk);
        sar_valid_in = 1'b0;
        @(negedge clk);
        check("idle_valid result_out", 32'(result_out), 32'h2003);
        check("idle_valid no pulse", 32'(result_valid_out), 32'h0);

        // abort coincident with sar_valid: abort wins
        burst_len_in = 8'd1;
        holdoff_in = 6'd0;
        start_conversion_in = 1'b1;
        @(negedge clk);
        check("abort arm", 32'(sar_start_out), 32'h1);
        start_conversion_in = 1'b0;
        @(negedge clk);
        sar_valid_in = 1'b1;
        abort_in = 1'b1;
        sar_result_in = 16'h5555;
        @(negedge clk);
        sar_valid_in = 1'b0;
        abort_in = 1'b0;
        check("abort busy", 32'(busy_out), 32'h0);
        check("abort result_valid", 32'(result_valid_out), 32'h0);
        check("abort finished", 32'(conversion_finished_out), 32'h0);
        check("abort result_out", 32'(result_out), 32'h2003);
        @(negedge clk);
        check("abort late result_valid", 32'(result_valid_out), 32'h0);
        check("abort late finished", 32'(conversion_finished_out), 32'h0);

        // second start edge during WAIT, then reset mid-HOLD
        burst_len_in = 8'd2;
        holdoff_in = 6'd10;
        start_conversion_in = 1'b1;
        @(negedge clk);
        check("rstseq arm", 32'(sar_start_out), 32'h1);
        start_conversion_in = 1'b0;
        @(negedge clk);
        start_conversion_in = 1'b1;
        @(negedge clk);
        start_conversion_in = 1'b0;
        check("rstseq edge ignored", 32'(sar_start_out), 32'h0);
        sar_valid_in = 1'b1;
        sar_result_in = 16'h3333;
        @(negedge clk);
        sar_valid_in = 1'b0;
        check("rstseq capture valid", 32'(result_valid_out), 32'h1);
        check("rstseq capture value", 32'(result_out), 32'h3333);
        check("rstseq capture not finished", 32'(conversion_finished_out), 32'h0);
        @(negedge clk);
        check("rstseq in hold busy", 32'(busy_out), 32'h1);
        check("rstseq in hold no start", 32'(sar_start_out), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midhold_reset");
        repeat (12) @(negedge clk);
        check("post_reset stays idle", 32'(busy_out), 32'h0);

`ifdef ADC_SCHED_TIMEOUT_EN
        // watchdog: 255 WAIT cycles without an answer
        burst_len_in = 8'd1;
        start_conversion_in = 1'b1;
        @(negedge clk);
        start_conversion_in = 1'b0;
        n_wait = 0;
        n_fin_to = 0;
        for (int c = 0; c < 400 && busy_out; c++) begin
            if (!sar_start_out) n_wait++;
            @(negedge clk);
            if (conversion_finished_out) n_fin_to++;
        end
        check("timeout wait cycles", 32'(n_wait), 32'd255);
        check("timeout idle", 32'(busy_out), 32'h0);
        check("timeout flag set", 32'(timeout_err_out), 32'h1);
        check("timeout no finished", 32'(n_fin_to), 32'h0);
        start_conversion_in = 1'b1;
        @(negedge clk);
        start_conversion_in = 1'b0;
        check("timeout flag cleared", 32'(timeout_err_out), 32'h0);
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        @(negedge clk);
        check("timeout cleanup idle", 32'(busy_out), 32'h0);
`else
        // without the watchdog WAIT holds indefinitely
        burst_len_in = 8'd1;
        start_conversion_in = 1'b1;
        @(negedge clk);
        start_conversion_in = 1'b0;
        n_wait = 0;
        n_fin_to = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (busy_out) n_wait++;
            if (conversion_finished_out) n_fin_to++;
        end
        check("unbounded wait busy cycles", 32'(n_wait), 32'd300);
        check("unbounded wait no flag", 32'(timeout_err_out), 32'h0);
        check("unbounded wait no finished", 32'(n_fin_to), 32'h0);
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        check("unbounded abort idle", 32'(busy_out), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
